trap_info_collector: RTL and testbench
======================================

# trap_info_collector

Producer side of the trap-cause encoding: collects exception reports from the pipeline, keeps only the oldest by ROB age, and hands a single `rv_trap_t::exception` cause plus `robIdx_t` and tval to the commit stage when that instruction reaches the ROB head. It sits between the execute/LSU writeback ports and the ROB commit logic, and holds at most one trap record.

## Interface
- `REPORT_PORTS`, 4: number of exception report ports (writeback and LSU).
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `i_report_vld`  in  REPORT_PORTS  per-port exception report valid.
- `i_report_robIdx`  in  REPORT_PORTS x robIdx_t  ROB index of the faulting instruction.
- `i_report_cause`  in  REPORT_PORTS x rv_trap_t::exception  16-bit cause.
- `i_report_tval`  in  REPORT_PORTS x 64  faulting address or instruction bits.
- `i_squash_vld`  in  1  branch/memdep redirect.
- `i_squash_robIdx`  in  robIdx_t  first killed ROB index; that index and every younger one is killed.
- `i_flush`  in  1  global pipeline flush; kills everything.
- `i_head_vld`  in  1  ROB head is valid.
- `i_head_robIdx`  in  robIdx_t  ROB head index.
- `o_pending`  out  1  a trap record is held (EMPTY is false).
- `o_pending_robIdx`  out  robIdx_t  index of the held record.
- `o_trap_vld`  out  1  trap presented to commit.
- `o_trap_robIdx`  out  robIdx_t, `o_trap_cause` out 16, `o_trap_tval` out 64: the presented record.
- `i_trap_ack`  in  1  commit has taken the trap.

## Operation
- Age: `older(a,b)` = `a.flipped==b.flipped ? a.idx<b.idx : a.idx>b.idx`. Equal indices are not older.
- Same-cycle selection: pick the oldest valid report. On equal robIdx, the lowest port number wins.
- Reports not older than `i_squash_robIdx` are dropped in the same cycle that `i_squash_vld` is high.
- States are EMPTY, HELD and REPORT.
- EMPTY → HELD when a surviving report arrives; the record is latched.
- HELD:
  - A surviving report strictly older than the record replaces it. An equal or younger report is ignored.
  - Squash kills the record if it is not older than `i_squash_robIdx`. If a report also survives in that cycle, the report is latched (HELD); otherwise → EMPTY.
  - When `i_head_vld` is high and `i_head_robIdx` equals the record's robIdx → REPORT.
- REPORT:
  - `o_trap_vld`=1 and the record is frozen. Reports and squash are ignored, because the head cannot be younger than anything.
  - `i_trap_ack` → EMPTY.
- `i_flush` has the highest priority in any state: the next state is EMPTY and all inputs in that cycle are discarded.
- In REPORT, ack and flush in the same cycle both lead to EMPTY.

## Timing
- Reset: state EMPTY. Every output is 0, including `o_pending_robIdx`, `o_trap_cause` and `o_trap_tval`.
- All outputs are registered.
- Report in cycle t → `o_pending`=1 in cycle t+1.
- Head match sampled in cycle t+1 → `o_trap_vld`=1 in cycle t+2.
- `o_trap_vld` stays high until the cycle after `i_trap_ack`. It is 0 in the cycle following the ack.
- Back-to-back: a report in the ack cycle is dropped, because commit flushes afterwards.
- Wrap-around: the flipped bit resolves age across the 128-entry boundary. Example: {1,3} is younger than {0,127}.

## Configuration
- `TRAP_TVAL_EN` defined:
  - tval is stored (64 flops) and replaced together with the cause.
- Undefined:
  - No tval storage.
  - `o_trap_tval` is tied to 0.
  - `i_report_tval` is unused.

## Structure
- `core_comm.svh` gains:
  - `typedef struct packed {robIdx_t robIdx; rv_trap_t::exception cause; logic[63:0] tval;} trapReport_t;`
  - the shared `robIdx_older` function, reused by the LSU and ROB.
- Sub-module `trap_report_select`:
  - combinational oldest-of-N tree (log2 levels) that returns the winner valid bit and the winning `trapReport_t`.
- The top level holds the state machine and the record register.

## Test plan
- Reset, then idle: all outputs stay 0 for 10 cycles.
- Same-cycle reports:
  - Stimulus: port0 {0,20} loadFault, port2 {0,5} instIllegal, port3 {0,5} breakpoint.
  - Required: record is {0,5} instIllegal.
  - Then head={0,5} → `o_trap_vld` two cycles after the report. Ack → `o_trap_vld` is 0 the next cycle.
- Wrap:
  - Stimulus: held {1,2} storeFault, then a report {0,126} fetchFault.
  - Required: the record is replaced by {0,126}. A later report {1,1} is ignored.
- Squash:
  - Stimulus: held {0,40}; `i_squash_robIdx`={0,40} together with a report {0,39} ucall.
  - Required: record is {0,39}. A squash at {0,30} then empties the collector (`o_pending`=0).
- Flush during REPORT:
  - Stimulus: REPORT {0,9} mcall; assert `i_flush` without ack.
  - Required: all outputs 0 the next cycle. A new report then restarts from EMPTY.
- Config:
  - With `TRAP_TVAL_EN`, a report with tval=0x80001000 presents that value.
  - Without it, `o_trap_tval` is 0.

Source files
------------

// File: rtl/trap_info_collector_pkg.sv
// Shared types for the trap-cause producer: ROB index, exception cause,
// trap report record, collector states and the ROB age comparison.
package trap_info_collector_pkg;

    localparam int unsigned ROB_IDX_W = 7;

    // ROB index with wrap bit; flipped toggles each time idx wraps past 127.
    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    // 16-bit exception cause code.
    typedef logic [15:0] exception_t;

    localparam exception_t EXC_FETCH_FAULT = 16'd1;
    localparam exception_t EXC_INST_ILLEGAL = 16'd2;
    localparam exception_t EXC_BREAKPOINT = 16'd3;
    localparam exception_t EXC_LOAD_FAULT = 16'd5;
    localparam exception_t EXC_STORE_FAULT = 16'd7;
    localparam exception_t EXC_UCALL = 16'd8;
    localparam exception_t EXC_MCALL = 16'd11;

    typedef struct packed {
        robIdx_t     robIdx;
        exception_t  cause;
        logic [63:0] tval;
    } trapReport_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HELD,
        ST_REPORT
    } trap_state_t;

    // True when a is strictly older than b; equal indices are not older.
    function automatic logic robIdx_older(robIdx_t a, robIdx_t b);
        return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/trap_info_collector_if.sv
// Report, squash, head and trap handshake signals of trap_info_collector.
// master: pipeline/commit side that drives reports and acks.
// slave:  the collector itself.
interface trap_info_collector_if #(
    parameter int unsigned REPORT_PORTS = 4
);
    import trap_info_collector_pkg::*;

    logic       [REPORT_PORTS-1:0]       i_report_vld;
    robIdx_t    [REPORT_PORTS-1:0]       i_report_robIdx;
    exception_t [REPORT_PORTS-1:0]       i_report_cause;
    logic       [REPORT_PORTS-1:0][63:0] i_report_tval;
    logic                                i_squash_vld;
    robIdx_t                             i_squash_robIdx;
    logic                                i_flush;
    logic                                i_head_vld;
    robIdx_t                             i_head_robIdx;
    logic                                o_pending;
    robIdx_t                             o_pending_robIdx;
    logic                                o_trap_vld;
    robIdx_t                             o_trap_robIdx;
    exception_t                          o_trap_cause;
    logic       [63:0]                   o_trap_tval;
    logic                                i_trap_ack;

    modport master (
        output i_report_vld, i_report_robIdx, i_report_cause, i_report_tval,
        output i_squash_vld, i_squash_robIdx, i_flush,
        output i_head_vld, i_head_robIdx, i_trap_ack,
        input  o_pending, o_pending_robIdx,
        input  o_trap_vld, o_trap_robIdx, o_trap_cause, o_trap_tval
    );

    modport slave (
        input  i_report_vld, i_report_robIdx, i_report_cause, i_report_tval,
        input  i_squash_vld, i_squash_robIdx, i_flush,
        input  i_head_vld, i_head_robIdx, i_trap_ack,
        output o_pending, o_pending_robIdx,
        output o_trap_vld, o_trap_robIdx, o_trap_cause, o_trap_tval
    );

endinterface

// File: rtl/trap_report_select.sv
// Combinational oldest-of-N selection tree over trap reports.
// On equal ROB index the lower-numbered input wins.
module trap_report_select
    import trap_info_collector_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic        [N-1:0] in_vld,
    input  trapReport_t [N-1:0] in_rep,
    output logic                out_vld,
    output trapReport_t         out_rep
);

    localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int unsigned P = 1 << LEVELS;

    // Level 0 holds the (padded) inputs; each higher level halves the width.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned W = P >> l;
        logic        [W-1:0] vld;
        trapReport_t [W-1:0] rep;

        if (l == 0) begin : g_leaf
            for (genvar n = 0; n < W; n++) begin : g_n
                if (n < N) begin : g_in
                    assign vld[n] = in_vld[n];
                    assign rep[n] = in_rep[n];
                end else begin : g_pad
                    assign vld[n] = 1'b0;
                    assign rep[n] = '0;
                end
            end
        end else begin : g_node
            for (genvar n = 0; n < W; n++) begin : g_n
                logic take_right;
                // Right child wins only when strictly older, keeping the lower port on ties.
                assign take_right = g_lvl[l-1].vld[2*n+1] &&
                                    (!g_lvl[l-1].vld[2*n] ||
                                     robIdx_older(g_lvl[l-1].rep[2*n+1].robIdx,
                                                  g_lvl[l-1].rep[2*n].robIdx));
                assign vld[n] = g_lvl[l-1].vld[2*n] | g_lvl[l-1].vld[2*n+1];
                assign rep[n] = take_right ? g_lvl[l-1].rep[2*n+1] : g_lvl[l-1].rep[2*n];
            end
        end
    end

    assign out_vld = g_lvl[LEVELS].vld[0];
    assign out_rep = g_lvl[LEVELS].rep[0];

endmodule

// File: rtl/trap_info_collector.sv
// trap_info_collector: keeps the oldest reported exception and presents it to
// commit once that instruction reaches the ROB head.
// Optional feature: define TRAP_TVAL_EN to store and present tval; otherwise
// o_trap_tval is tied to 0 and i_report_tval is ignored.
module trap_info_collector
    import trap_info_collector_pkg::*;
#(
    parameter int unsigned REPORT_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    trap_info_collector_if.slave bus
);

    logic        [REPORT_PORTS-1:0] surv_vld;
    trapReport_t [REPORT_PORTS-1:0] surv_rep;
    logic                           win_vld;
    trapReport_t                    win_rep;

    trap_state_t state;
    logic        pending;
    robIdx_t     rec_robIdx;
    exception_t  rec_cause;
    logic        trap_vld;
    robIdx_t     trap_robIdx;
    exception_t  trap_cause;
    logic        rec_killed;
    logic        win_older;
    logic        head_hit;

`ifdef TRAP_TVAL_EN
    logic [63:0] rec_tval;
    logic [63:0] trap_tval;
`endif

    // Drop reports killed by a same-cycle squash and pack the survivors.
    always_comb begin
        surv_vld = '0;
        surv_rep = '0;
        for (int unsigned p = 0; p < REPORT_PORTS; p++) begin
            surv_vld[p] = bus.i_report_vld[p] &&
                          !(bus.i_squash_vld &&
                            !robIdx_older(bus.i_report_robIdx[p], bus.i_squash_robIdx));
            surv_rep[p].robIdx = bus.i_report_robIdx[p];
            surv_rep[p].cause  = bus.i_report_cause[p];
`ifdef TRAP_TVAL_EN
            surv_rep[p].tval   = bus.i_report_tval[p];
`endif
        end
    end

    trap_report_select #(
        .N(REPORT_PORTS)
    ) u_select (
        .in_vld (surv_vld),
        .in_rep (surv_rep),
        .out_vld(win_vld),
        .out_rep(win_rep)
    );

    // Relations between the held record and this cycle's squash, winner and head.
    always_comb begin
        rec_killed = bus.i_squash_vld && !robIdx_older(rec_robIdx, bus.i_squash_robIdx);
        win_older  = win_vld && robIdx_older(win_rep.robIdx, rec_robIdx);
        head_hit   = bus.i_head_vld && (bus.i_head_robIdx == rec_robIdx);
    end

    // Collector state machine with the record and all output registers.
    always_ff @(posedge clk) begin
        if (rst || bus.i_flush) begin
            state       <= ST_EMPTY;
            pending     <= 1'b0;
            rec_robIdx  <= '0;
            rec_cause   <= '0;
            trap_vld    <= 1'b0;
            trap_robIdx <= '0;
            trap_cause  <= '0;
`ifdef TRAP_TVAL_EN
            rec_tval    <= '0;
            trap_tval   <= '0;
`endif
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (win_vld) begin
                        state      <= ST_HELD;
                        pending    <= 1'b1;
                        rec_robIdx <= win_rep.robIdx;
                        rec_cause  <= win_rep.cause;
`ifdef TRAP_TVAL_EN
                        rec_tval   <= win_rep.tval;
`endif
                    end
                end
                ST_HELD: begin
                    // A survivor is always older than the squash point, so it
                    // replaces a killed record just as it replaces a younger one.
                    if (win_vld && (rec_killed || win_older)) begin
                        rec_robIdx <= win_rep.robIdx;
                        rec_cause  <= win_rep.cause;
`ifdef TRAP_TVAL_EN
                        rec_tval   <= win_rep.tval;
`endif
                    end else if (rec_killed) begin
                        state      <= ST_EMPTY;
                        pending    <= 1'b0;
                        rec_robIdx <= '0;
                        rec_cause  <= '0;
`ifdef TRAP_TVAL_EN
                        rec_tval   <= '0;
`endif
                    end else if (head_hit) begin
                        state       <= ST_REPORT;
                        trap_vld    <= 1'b1;
                        trap_robIdx <= rec_robIdx;
                        trap_cause  <= rec_cause;
`ifdef TRAP_TVAL_EN
                        trap_tval   <= rec_tval;
`endif
                    end
                end
                ST_REPORT: begin
                    if (bus.i_trap_ack) begin
                        state       <= ST_EMPTY;
                        pending     <= 1'b0;
                        rec_robIdx  <= '0;
                        rec_cause   <= '0;
                        trap_vld    <= 1'b0;
                        trap_robIdx <= '0;
                        trap_cause  <= '0;
`ifdef TRAP_TVAL_EN
                        rec_tval    <= '0;
                        trap_tval   <= '0;
`endif
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.o_pending        = pending;
    assign bus.o_pending_robIdx = rec_robIdx;
    assign bus.o_trap_vld       = trap_vld;
    assign bus.o_trap_robIdx    = trap_robIdx;
    assign bus.o_trap_cause     = trap_cause;

`ifdef TRAP_TVAL_EN
    assign bus.o_trap_tval = trap_tval;
`else
    assign bus.o_trap_tval = '0;
    logic unused_tval;
    assign unused_tval = ^{bus.i_report_tval, win_rep.tval};
`endif

endmodule

// File: tb/tb_trap_info_collector.sv
// Testbench for trap_info_collector: directed scenarios plus a short random
// phase, checked every cycle against a circular-distance age model.
module tb_trap_info_collector;
    import trap_info_collector_pkg::*;

    localparam int unsigned NP = 4;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail = 0;

    trap_info_collector_if #(.REPORT_PORTS(NP)) bus ();

    trap_info_collector #(
        .REPORT_PORTS(NP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: whether a record exists, whether it is being presented.
    bit          m_held;
    bit          m_pres;
    logic [7:0]  m_rob;
    logic [15:0] m_cause;
    logic [63:0] m_tval;

    // a older than b: going forward from a to b on the 256-step ring takes
    // fewer than 128 steps, i.e. b - a mod 256 in 1..127.
    function automatic bit age_older(logic [7:0] a, logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        return d > 8'd128;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_held  = 0;
        m_pres  = 0;
        m_rob   = '0;
        m_cause = '0;
        m_tval  = '0;
    endtask

    // Reference behaviour evaluated on each rising edge.
    always @(posedge clk) begin
        int         best;
        logic [7:0] r;
        logic [7:0] brob;
        if (rst || bus.i_flush) begin
            model_clear();
        end else if (m_pres) begin
            if (bus.i_trap_ack) model_clear();
        end else begin
            best = -1;
            brob = '0;
            for (int p = 0; p < NP; p++) begin
                r = bus.i_report_robIdx[p];
                if (bus.i_report_vld[p] &&
                    !(bus.i_squash_vld && !age_older(r, bus.i_squash_robIdx)) &&
                    (best < 0 || age_older(r, brob))) begin
                    best = p;
                    brob = r;
                end
            end
            if (m_held && bus.i_squash_vld && !age_older(m_rob, bus.i_squash_robIdx)) begin
                model_clear();
            end
            if (best >= 0 && (!m_held || age_older(brob, m_rob))) begin
                m_held  = 1;
                m_rob   = brob;
                m_cause = bus.i_report_cause[best];
                m_tval  = bus.i_report_tval[best];
            end else if (m_held && bus.i_head_vld && bus.i_head_robIdx == m_rob) begin
                m_pres = 1;
            end
        end
    end

    // Compare every output against the model just after each rising edge.
    always @(posedge clk) begin
        logic [63:0] exp_tval;
        #1;
`ifdef TRAP_TVAL_EN
        exp_tval = m_pres ? m_tval : 64'd0;
`else
        exp_tval = 64'd0;
`endif
        check("cmp_pending", 64'(bus.o_pending), 64'(m_held));
        check("cmp_pending_robIdx", 64'(bus.o_pending_robIdx), 64'(m_rob));
        check("cmp_trap_vld", 64'(bus.o_trap_vld), 64'(m_pres));
        check("cmp_trap_robIdx", 64'(bus.o_trap_robIdx), m_pres ? 64'(m_rob) : 64'd0);
        check("cmp_trap_cause", 64'(bus.o_trap_cause), m_pres ? 64'(m_cause) : 64'd0);
        check("cmp_trap_tval", bus.o_trap_tval, exp_tval);
    end

    task automatic clear_inputs();
        bus.i_report_vld    = '0;
        bus.i_report_robIdx = '0;
        bus.i_report_cause  = '0;
        bus.i_report_tval   = '0;
        bus.i_squash_vld    = 1'b0;
        bus.i_squash_robIdx = '0;
        bus.i_flush         = 1'b0;
        bus.i_head_vld      = 1'b0;
        bus.i_head_robIdx   = '0;
        bus.i_trap_ack      = 1'b0;
    endtask

    // One clock: inputs set before the call are consumed at the rising edge.
    task automatic step();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic report(input int p, input logic [7:0] rob, input logic [15:0] cause,
                          input logic [63:0] tval);
        bus.i_report_vld[p]    = 1'b1;
        bus.i_report_robIdx[p] = rob;
        bus.i_report_cause[p]  = cause;
        bus.i_report_tval[p]   = tval;
    endtask

    task automatic head(input logic [7:0] rob);
        bus.i_head_vld    = 1'b1;
        bus.i_head_robIdx = rob;
    endtask

    task automatic squash(input logic [7:0] rob);
        bus.i_squash_vld    = 1'b1;
        bus.i_squash_robIdx = rob;
    endtask

    // Stimulus with hand-computed expectations.
    initial begin
        logic [7:0]  base;
        logic [63:0] exp_tv;
        clear_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset.
        repeat (10) step();
        check("idle_pending", 64'(bus.o_pending), 64'd0);
        check("idle_trap_vld", 64'(bus.o_trap_vld), 64'd0);

        // Same-cycle selection: {0,5} on port 2 beats {0,20} and the port-3 tie.
        report(0, 8'd20, EXC_LOAD_FAULT, 64'h11);
        report(2, 8'd5, EXC_INST_ILLEGAL, 64'h22);
        report(3, 8'd5, EXC_BREAKPOINT, 64'h33);
        step();
        check("sel_pending", 64'(bus.o_pending), 64'd1);
        check("sel_robIdx", 64'(bus.o_pending_robIdx), 64'd5);
        check("sel_trap_vld_early", 64'(bus.o_trap_vld), 64'd0);
        head(8'd5);
        step();
        check("sel_trap_vld", 64'(bus.o_trap_vld), 64'd1);
        check("sel_trap_cause", 64'(bus.o_trap_cause), 64'(EXC_INST_ILLEGAL));
        check("sel_trap_robIdx", 64'(bus.o_trap_robIdx), 64'd5);
        step();
        check("sel_trap_hold", 64'(bus.o_trap_vld), 64'd1);
        bus.i_trap_ack = 1'b1;
        step();
        check("sel_after_ack", 64'(bus.o_trap_vld), 64'd0);
        check("sel_after_ack_pend", 64'(bus.o_pending), 64'd0);

        // Wrap: {0,126} is older than {1,2}; {1,1} is younger than {0,126}.
        report(1, 8'h82, EXC_STORE_FAULT, 64'h44);
        step();
        check("wrap_first", 64'(bus.o_pending_robIdx), 64'h82);
        report(0, 8'h7E, EXC_FETCH_FAULT, 64'h55);
        step();
        check("wrap_replace", 64'(bus.o_pending_robIdx), 64'h7E);
        report(3, 8'h81, EXC_LOAD_FAULT, 64'h66);
        step();
        check("wrap_ignore", 64'(bus.o_pending_robIdx), 64'h7E);
        head(8'h7E);
        step();
        check("wrap_cause", 64'(bus.o_trap_cause), 64'(EXC_FETCH_FAULT));
        bus.i_trap_ack = 1'b1;
        step();

        // Squash at {0,40} kills the held {0,40} but keeps the {0,39} report.
        report(0, 8'd40, EXC_LOAD_FAULT, 64'h77);
        step();
        squash(8'd40);
        report(1, 8'd39, EXC_UCALL, 64'h88);
        step();
        check("sq_latch", 64'(bus.o_pending_robIdx), 64'd39);
        check("sq_pending", 64'(bus.o_pending), 64'd1);
        squash(8'd30);
        step();
        check("sq_empty", 64'(bus.o_pending), 64'd0);

        // Flush while presenting, then restart from empty.
        report(2, 8'd9, EXC_MCALL, 64'h99);
        step();
        head(8'd9);
        step();
        check("fl_trap_vld", 64'(bus.o_trap_vld), 64'd1);
        bus.i_flush = 1'b1;
        step();
        check("fl_trap_vld0", 64'(bus.o_trap_vld), 64'd0);
        check("fl_pending0", 64'(bus.o_pending), 64'd0);
        check("fl_cause0", 64'(bus.o_trap_cause), 64'd0);
        report(0, 8'd50, EXC_BREAKPOINT, 64'hAA);
        step();
        check("fl_restart", 64'(bus.o_pending_robIdx), 64'd50);
        bus.i_flush = 1'b1;
        step();

        // tval presentation, then a report in the ack cycle is dropped.
        report(3, 8'd60, EXC_INST_ILLEGAL, 64'h8000_1000);
        step();
        head(8'd60);
        step();
`ifdef TRAP_TVAL_EN
        exp_tv = 64'h8000_1000;
`else
        exp_tv = 64'd0;
`endif
        check("tval_present", bus.o_trap_tval, exp_tv);
        bus.i_trap_ack = 1'b1;
        report(0, 8'd61, EXC_LOAD_FAULT, 64'hBB);
        step();
        check("ack_drop", 64'(bus.o_pending), 64'd0);

        // Ack and flush together.
        report(1, 8'd3, EXC_UCALL, 64'hCC);
        step();
        head(8'd3);
        step();
        bus.i_trap_ack = 1'b1;
        bus.i_flush    = 1'b1;
        step();
        check("ackflush_empty", 64'(bus.o_pending), 64'd0);

        // Random traffic within a small age window that drifts across the wrap.
        base = 8'd100;
        for (int c = 0; c < 400; c++) begin
            if (c % 8 == 0) base = base + 8'd3;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0)
                    report(p, 8'(base + 8'($urandom_range(0, 20))),
                           16'($urandom_range(0, 15)),
                           {$urandom, $urandom});
            end
            if ($urandom_range(0, 9) == 0) squash(8'(base + 8'($urandom_range(0, 20))));
            if ($urandom_range(0, 39) == 0) bus.i_flush = 1'b1;
            if (m_held && !m_pres && $urandom_range(0, 2) == 0) head(m_rob);
            if (m_pres && $urandom_range(0, 2) == 0) bus.i_trap_ack = 1'b1;
            step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
